// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: machine word, RAM handshake state and
// the RAM arbiter's FSM state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-ported RAM between the I-cache and D-cache ports, data first.
// Define ARB_FAIR_EN to add a starvation counter that forces an instruction grant.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  arb_state_t state_q, state_d;

  logic d_req;
  logic d_done;
  logic i_done;
  logic i_first;

  assign d_req  = dREN | dWEN;
  assign d_done = (state_q == DGRANT) && d_req && (ramstate == ACCESS);
  assign i_done = (state_q == IGRANT) && iREN && (ramstate == ACCESS);

`ifdef ARB_FAIR_EN
  logic [3:0] starve_q, starve_d;

  assign i_first = iREN && (starve_q >= 4'(STARVE_LIMIT));

  // Counts data completions that happened while a fetch was left waiting.
  always_comb begin
    starve_d = starve_q;
    if (d_done) begin
      if (!iREN)                 starve_d = 4'd0;
      else if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
    end else if (i_done) begin
      starve_d = 4'd0;
    end
  end
`else
  assign i_first = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_first)    state_d = IGRANT;
        else if (d_req) state_d = DGRANT;
        else if (iREN)  state_d = IGRANT;
      end
      // Leave on completion, on ERROR (retry via IDLE) or on withdrawal.
      DGRANT: begin
        if (!d_req || ramstate == ACCESS || ramstate == ERROR) state_d = IDLE;
      end
      IGRANT: begin
        if (!iREN || ramstate == ACCESS || ramstate == ERROR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM side follows the live request inputs so a withdrawal drops the enables at once.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (d_done) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (i_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
`ifdef ARB_FAIR_EN
      starve_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
`ifdef ARB_FAIR_EN
      starve_q <= starve_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter; expected outputs go through a scoreboard queue.
// Build with ARB_FAIR_EN defined to exercise the fairness sequence.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string     name;
    logic      rst_n, ir, dr, dw;
    word_t     ia, da, ds, rl;
    ramstate_t rs;
    logic      e_iw, e_dw, e_ren, e_wen;
    word_t     e_addr, e_store, e_il, e_dl;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_checks = 0;

  function automatic vec_t mk(string name, logic rst_n, logic ir, logic dr, logic dw,
                              word_t ia, word_t da, word_t ds, word_t rl, ramstate_t rs,
                              logic e_iw, logic e_dw, logic e_ren, logic e_wen,
                              word_t e_addr, word_t e_store, word_t e_il, word_t e_dl);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.ir = ir; v.dr = dr; v.dw = dw;
    v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
    v.e_iw = e_iw; v.e_dw = e_dw; v.e_ren = e_ren; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_store = e_store; v.e_il = e_il; v.e_dl = e_dl;
    return v;
  endfunction

  task automatic check_out();
    vec_t        e;
    logic [131:0] act, req;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard: got empty queue, required an expected entry");
      return;
    end
    e   = exp_q.pop_front();
    act = {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload};
    req = {e.e_iw, e.e_dw, e.e_ren, e.e_wen, e.e_addr, e.e_store, e.e_il, e.e_dl};
    if (act === req) n_pass++;
    else $display("FAIL %s: got iw/dw/ren/wen/addr/store/iload/dload=%h required %h",
                  e.name, act, req);
  endtask

  // Drive one cycle's inputs just after the edge, check outputs on the falling edge.
  task automatic apply(input vec_t v);
    @(posedge CLK);
    #1;
    nRST = v.rst_n; iREN = v.ir; dREN = v.dr; dWEN = v.dw;
    iaddr = v.ia; daddr = v.da; dstore = v.ds; ramload = v.rl; ramstate = v.rs;
    exp_q.push_back(v);
    @(negedge CLK);
    check_out();
  endtask

  initial begin
    bit fair;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
`ifdef ARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif

    // reset with every request asserted, then data wins the first arbitration
    vecs.push_back(mk("rst0", 0,1,1,1, 32'h40,32'h100,32'hDEADBEEF,32'hCAFE,ACCESS, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("rst1", 0,1,1,1, 32'h40,32'h100,32'hDEADBEEF,32'hCAFE,ACCESS, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("rel_idle", 1,1,1,0, 32'h40,32'h10,32'h77,0,FREE, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("rel_dgrant", 1,1,1,0, 32'h40,32'h10,32'h77,32'hAAAA5555,ACCESS,
                      1,0,1,0, 32'h10,32'h77,0,32'hAAAA5555));
    vecs.push_back(mk("idle0", 1,0,0,0, 0,0,0,0,FREE, 1,1,0,0, 0,0,0,0));
    // single fetch with two BUSY cycles
    vecs.push_back(mk("f_idle", 1,1,0,0, 32'h40,0,0,0,FREE, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("f_busy1", 1,1,0,0, 32'h40,0,0,0,BUSY, 1,1,1,0, 32'h40,0,0,0));
    vecs.push_back(mk("f_busy2", 1,1,0,0, 32'h40,0,0,0,BUSY, 1,1,1,0, 32'h40,0,0,0));
    vecs.push_back(mk("f_access", 1,1,0,0, 32'h40,0,0,32'h24010005,ACCESS,
                      0,1,1,0, 32'h40,0,32'h24010005,0));
    vecs.push_back(mk("f_turn", 1,0,0,0, 32'h40,0,0,32'h24010005,ACCESS, 1,1,0,0, 0,0,0,0));
    // write and fetch in the same cycle; read+write together means write
    vecs.push_back(mk("c_idle", 1,1,1,1, 32'h80,32'h100,32'hDEADBEEF,0,FREE, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("c_write", 1,1,1,1, 32'h80,32'h100,32'hDEADBEEF,32'h5A5A5A5A,ACCESS,
                      1,0,0,1, 32'h100,32'hDEADBEEF,0,32'h5A5A5A5A));
    vecs.push_back(mk("c_turn", 1,1,0,0, 32'h80,32'h100,32'hDEADBEEF,0,FREE, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("c_fetch", 1,1,0,0, 32'h80,32'h100,32'hDEADBEEF,32'h0BADF00D,ACCESS,
                      0,1,1,0, 32'h80,0,32'h0BADF00D,0));
    vecs.push_back(mk("c_done", 1,0,0,0, 0,0,0,0,FREE, 1,1,0,0, 0,0,0,0));
    // ERROR forces a retry through IDLE
    vecs.push_back(mk("e_idle", 1,0,1,0, 0,32'h200,0,0,FREE, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("e_error", 1,0,1,0, 0,32'h200,0,32'hFFFFFFFF,ERROR, 1,1,1,0, 32'h200,0,0,0));
    vecs.push_back(mk("e_retry_idle", 1,0,1,0, 0,32'h200,0,32'hFFFFFFFF,ERROR, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("e_access", 1,0,1,0, 0,32'h200,0,32'h12345678,ACCESS,
                      1,0,1,0, 32'h200,0,0,32'h12345678));
    vecs.push_back(mk("e_done", 1,0,0,0, 0,0,0,0,FREE, 1,1,0,0, 0,0,0,0));
    // withdrawal while BUSY, then a fetch proves the FSM is back in IDLE
    vecs.push_back(mk("w_idle", 1,0,1,0, 0,32'h300,32'h11,0,FREE, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("w_busy", 1,0,1,0, 0,32'h300,32'h11,0,BUSY, 1,1,1,0, 32'h300,32'h11,0,0));
    vecs.push_back(mk("w_drop", 1,0,0,0, 0,32'h300,32'h11,0,BUSY, 1,1,0,0, 32'h300,32'h11,0,0));
    vecs.push_back(mk("w_after", 1,0,0,0, 0,32'h300,32'h11,32'h66,ACCESS, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("w_iidle", 1,1,0,0, 32'h44,0,0,32'h66,ACCESS, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("w_ifetch", 1,1,0,0, 32'h44,0,0,32'h77,ACCESS, 0,1,1,0, 32'h44,0,32'h77,0));
    // reset asserted mid-grant abandons the access
    vecs.push_back(mk("m_idle", 1,0,1,0, 0,32'h400,0,0,FREE, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("m_rst", 0,0,1,0, 0,32'h400,0,0,BUSY, 1,1,1,0, 32'h400,0,0,0));
    vecs.push_back(mk("m_after", 1,0,1,0, 0,32'h400,0,32'h55,ACCESS, 1,1,0,0, 0,0,0,0));
    vecs.push_back(mk("m_grant", 1,0,1,0, 0,32'h400,0,32'h55,ACCESS, 1,0,1,0, 32'h400,0,0,32'h55));
    vecs.push_back(mk("m_done", 1,0,0,0, 0,0,0,0,FREE, 1,1,0,0, 0,0,0,0));

    foreach (vecs[i]) apply(vecs[i]);

    // Fetch held high against continuous data reads with a zero-latency RAM.
    // Strict priority: only data completes. Fair (limit 4): four data, then one fetch.
    for (int k = 0; k < 10; k++) begin
      bit instr;
      instr = fair && ((k % 5) == 4);
      apply(mk($sformatf("s_idle%0d", k), 1,1,1,0, 32'h500,32'h600,0,32'h99,ACCESS,
               1,1,0,0, 0,0,0,0));
      if (instr)
        apply(mk($sformatf("s_fetch%0d", k), 1,1,1,0, 32'h500,32'h600,0,32'h99,ACCESS,
                 0,1,1,0, 32'h500,0,32'h99,0));
      else
        apply(mk($sformatf("s_data%0d", k), 1,1,1,0, 32'h500,32'h600,0,32'h99,ACCESS,
                 1,0,1,0, 32'h600,0,0,32'h99));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential arbiter that shares the single-ported RAM between the instruction-side and data-side cache request ports of one CPU.
- Sits between the caches block (iREN/dREN/dWEN/iaddr/daddr/dstore out, iwait/dwait/iload/dload in) and the RAM model (ramstate handshake).
- Grants one requester at a time through a registered FSM.
- Holds the grant until RAM reports ACCESS, then releases it.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits. Used only when ARB_FAIR_EN is defined; legal range 1..15.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address (word_t)
- iwait  out  1  instruction stall; low for exactly the completing cycle
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data stall; low for exactly the completing cycle
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Clock CLK; reset nRST, synchronous, active-low. Reset is sampled on the CLK rising edge.
- Reset values:
  - state = IDLE
  - iwait = dwait = 1
  - ramREN = ramWEN = 0
  - ramaddr = ramstore = 0
  - iload = dload = 0
  - starvation counter = 0
- FSM states: IDLE, DGRANT, IGRANT (arb_state_t).
- IDLE transitions:
  - if (dREN|dWEN) -> DGRANT
  - else if iREN -> IGRANT
  - else stay in IDLE
  - Data side has fixed priority.
  - All RAM enables are 0 in IDLE, and both waits are 1.
- DGRANT outputs:
  - ramaddr = daddr, ramstore = dstore
  - ramWEN = dWEN
  - ramREN = dREN & ~dWEN (if both are high, the write wins)
  - iwait = 1
- IGRANT outputs:
  - ramaddr = iaddr, ramREN = 1, ramWEN = 0, ramstore = 0
  - dwait = 1
- Completion:
  - In the granted state, the cycle with ramstate == ACCESS drives the owner's wait to 0.
  - In that same cycle, the owner's load = ramload (combinational passthrough).
  - Next state = IDLE.
- Turnaround: one IDLE cycle always follows a grant, so back-to-back requests are re-arbitrated.
- Latency: with a zero-latency RAM (ACCESS on the first enabled cycle), a request seen in cycle N completes in cycle N+1.
- FREE or BUSY while granted: stay in the grant state; the wait stays 1.
- ERROR while granted:
  - The wait stays 1.
  - Next state = IDLE, and the request is re-arbitrated (retry).
  - No data is returned.
- Requester withdraws mid-grant (the owner's enables drop before ACCESS):
  - Next state = IDLE.
  - RAM enables are 0 in the same cycle because they follow the live inputs.
- Outside completion, iload/dload are 0.
- Address and store values pass through unmodified; there is no width conversion.
- Reset asserted mid-grant: all outputs take their reset values at the next edge; the in-flight access is abandoned.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A 4-bit counter increments on each DGRANT completion when iREN was high at that completion.
  - It clears on any IGRANT completion, or on a DGRANT completion with iREN low.
  - In IDLE, if counter >= STARVE_LIMIT and iREN is high, go to IGRANT even when a data request is pending.
- Undefined: the counter is absent and data priority is strict.

Decomposition:
- cpu_types_pkg carries:
  - word_t
  - ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
  - arb_state_t (IDLE, DGRANT, IGRANT)
- No sub-module: the FSM plus mux is one block, and the starvation counter stays inline under the macro.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with all requests high -> iwait=dwait=1, ramREN=ramWEN=0, ramaddr=0; after release, the first grant is DGRANT.
- Single fetch: iREN=1, iaddr=0x0000_0040, RAM ACCESS after 2 BUSY cycles with ramload=0x2401_0005 -> iwait low for exactly 1 cycle with iload=0x2401_0005, then 1 IDLE cycle.
- Conflict: iREN=1 and dWEN=1, daddr=0x0000_0100, dstore=0xDEAD_BEEF, in the same cycle:
  - the write is serviced first (ramWEN=1, ramstore=0xDEAD_BEEF, dwait drops)
  - then IDLE, then IGRANT services the fetch.
- ERROR retry: dREN=1, RAM returns ERROR then ACCESS with ramload=0x1234_5678 -> DGRANT, IDLE, DGRANT; dwait drops once with dload=0x1234_5678.
- Withdrawal: dREN=1 is granted, then dREN drops while ramstate=BUSY -> ramREN=0 in that cycle and the FSM returns to IDLE with no dwait pulse.
- ARB_FAIR_EN, STARVE_LIMIT=4: iREN held high and dREN pulsed continuously -> exactly 4 data completions, then 1 instruction completion, then the counter reads 0.
